local_mult_pipe: RTL and testbench

//  Parametrised pipelined multiplier; successor to the fixed 64x64->128 local multiplier.

---
 rtl/local_mult_pkg.sv | 31 +++
 rtl/local_mult_slot.sv | 36 +++
 rtl/local_mult_pipe.sv | 125 ++++++++++++
 tb/tb_local_mult_pipe.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/local_mult_pkg.sv
// Shared types and arithmetic for the local pipelined multiplier.
// Operands up to MAX_OP_W bits and products up to MAX_PROD_W bits are supported.
package local_mult_pkg;

  localparam int MAX_OP_W   = 64;
  localparam int MAX_PROD_W = 2 * MAX_OP_W;
  localparam int DEF_TAG_W  = 4;

  // Default lane op format; the top specialises it to its own widths.
  typedef struct packed {
    logic [MAX_PROD_W-1:0] product;
    logic [DEF_TAG_W-1:0]  tag;
    logic                  ovf;
  } mult_op_t;

  // Operands arrive already extended to MAX_OP_W according to is_signed, so the
  // MAX_PROD_W-bit result is the exact product for any operand width <= MAX_OP_W.
  function automatic logic [MAX_PROD_W-1:0] full_product(
    input logic [MAX_OP_W-1:0] a,
    input logic [MAX_OP_W-1:0] b,
    input logic                is_signed
  );
    logic signed [MAX_PROD_W-1:0] sa;
    logic signed [MAX_PROD_W-1:0] sb;
    sa = MAX_PROD_W'($signed(a));
    sb = MAX_PROD_W'($signed(b));
    if (is_signed) full_product = sa * sb;
    else           full_product = MAX_PROD_W'(a) * MAX_PROD_W'(b);
  endfunction

endpackage

// File: rtl/local_mult_slot.sv
// One pipeline slot of the local multiplier: a valid bit plus the op payload.
// The top decides when the slot loads from upstream and when its op drains downstream.
module local_mult_slot
  import local_mult_pkg::*;
#(
  parameter type op_t = mult_op_t
) (
  input  logic clock,
  input  logic aclr,
  input  logic clken,
  input  logic load,
  input  logic adv,
  input  op_t  up_op,
  output logic valid,
  output op_t  op
);

  // NOTE: sequential state uses non-blocking assignments so every slot samples
  // its neighbour's pre-edge value; blocking here would let ops skip slots.
  always_ff @(posedge clock) begin
    if (aclr) begin
      valid <= 1'b0;
      // NOTE: the payload is reset too, not just the valid bit, because the last
      // slot drives result/out_tag and those must read zero after reset.
      op    <= '0;
    end else if (clken) begin
      if (load) begin
        valid <= 1'b1;
        op    <= up_op;
      end else if (adv) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/local_mult_pipe.sv
// Parametrised pipelined multiplier with valid/ready handshake and bubble collapse.
// Define LOCAL_MULT_OVF_EN to build the ovf output that flags a truncated product.
module local_mult_pipe
  import local_mult_pkg::*;
#(
  parameter int LPM_WIDTHA = 64,
  parameter int LPM_WIDTHB = 64,
  parameter int LPM_WIDTHP = 128,
  parameter int STAGES     = 3,
  parameter int TAGW       = 4
) (
  input  logic                  clock,
  input  logic                  aclr,
  input  logic                  clken,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LPM_WIDTHA-1:0] dataa,
  input  logic [LPM_WIDTHB-1:0] datab,
  input  logic                  is_signed,
  input  logic [TAGW-1:0]       in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LPM_WIDTHP-1:0] result,
  output logic [TAGW-1:0]       out_tag,
  output logic                  busy
`ifdef LOCAL_MULT_OVF_EN
  ,
  output logic                  ovf
`endif
);

  typedef struct packed {
    logic [LPM_WIDTHP-1:0] product;
    logic [TAGW-1:0]       tag;
`ifdef LOCAL_MULT_OVF_EN
    logic                  ovf;
`endif
  } lane_op_t;

  logic [MAX_OP_W-1:0]   a_ext;
  logic [MAX_OP_W-1:0]   b_ext;
  logic [MAX_PROD_W-1:0] full;
  lane_op_t              issue_op;

  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] load;
  logic [STAGES-1:0] adv;
  lane_op_t          up_op    [STAGES];
  lane_op_t          stage_op [STAGES];

`ifdef LOCAL_MULT_OVF_EN
  logic issue_ovf;

  if (LPM_WIDTHP >= LPM_WIDTHA + LPM_WIDTHB) begin : g_no_trunc
    assign issue_ovf = 1'b0;
  end else begin : g_trunc
    // Bits P-1 and above: signed ops must see pure sign copies, unsigned ops zeros above P-1.
    logic [MAX_PROD_W-LPM_WIDTHP:0] upper;
    assign upper     = full[MAX_PROD_W-1:LPM_WIDTHP-1];
    assign issue_ovf = is_signed ? !((&upper) || !(|upper))
                                 : (|upper[MAX_PROD_W-LPM_WIDTHP:1]);
  end
`endif

  always_comb begin
    a_ext            = is_signed ? MAX_OP_W'($signed(dataa)) : MAX_OP_W'(dataa);
    b_ext            = is_signed ? MAX_OP_W'($signed(datab)) : MAX_OP_W'(datab);
    full             = full_product(a_ext, b_ext, is_signed);
    issue_op.product = full[LPM_WIDTHP-1:0];
    issue_op.tag     = in_tag;
`ifdef LOCAL_MULT_OVF_EN
    issue_op.ovf     = issue_ovf;
`endif
  end

  // Walk from the output back to the input: a slot drains when it holds an op and
  // the slot below is empty or draining in the same cycle, which collapses bubbles.
  always_comb begin
    logic down_ok;
    // NOTE: every variable written here gets a value before any branch, so no
    // path leaves one unassigned and no latch is inferred.
    adv     = '0;
    load    = '0;
    down_ok = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      adv[k]  = clken && valid[k] && down_ok;
      down_ok = !valid[k] || adv[k];
    end
    in_ready = clken && down_ok;
    load[0]  = in_valid && in_ready;
    for (int k = 1; k < STAGES; k++) begin
      load[k] = adv[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    if (k == 0) begin : g_head
      assign up_op[k] = issue_op;
    end else begin : g_body
      assign up_op[k] = stage_op[k-1];
    end

    local_mult_slot #(
      .op_t (lane_op_t)
    ) u_slot (
      .clock (clock),
      .aclr  (aclr),
      .clken (clken),
      .load  (load[k]),
      .adv   (adv[k]),
      .up_op (up_op[k]),
      .valid (valid[k]),
      .op    (stage_op[k])
    );
  end

  assign out_valid = valid[STAGES-1];
  assign result    = stage_op[STAGES-1].product;
  assign out_tag   = stage_op[STAGES-1].tag;
  assign busy      = |valid;
`ifdef LOCAL_MULT_OVF_EN
  assign ovf       = stage_op[STAGES-1].ovf;
`endif

endmodule

// File: tb/tb_local_mult_pipe.sv
// Bench for local_mult_pipe: a full-width instance and a 64-bit-product instance share
// stimulus and are checked against an arithmetic scoreboard of accepted ops.
module tb_local_mult_pipe;

  localparam int STAGES = 3;

  logic         clock = 1'b0;
  logic         aclr, clken, in_valid, is_signed, out_ready;
  logic [63:0]  dataa, datab;
  logic [3:0]   in_tag;
  logic         in_ready, out_valid, busy;
  logic [127:0] result;
  logic [3:0]   out_tag;
  logic         in_ready_t, out_valid_t, busy_t;
  logic [63:0]  result_t;
  logic [3:0]   out_tag_t;
`ifdef LOCAL_MULT_OVF_EN
  logic         ovf, ovf_t;
`endif

  always #5 clock = ~clock;

  local_mult_pipe #(
    .LPM_WIDTHA(64), .LPM_WIDTHB(64), .LPM_WIDTHP(128), .STAGES(STAGES), .TAGW(4)
  ) dut (
    .clock(clock), .aclr(aclr), .clken(clken), .in_valid(in_valid), .in_ready(in_ready),
    .dataa(dataa), .datab(datab), .is_signed(is_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag),
    .busy(busy)
`ifdef LOCAL_MULT_OVF_EN
    , .ovf(ovf)
`endif
  );

  local_mult_pipe #(
    .LPM_WIDTHA(64), .LPM_WIDTHB(64), .LPM_WIDTHP(64), .STAGES(STAGES), .TAGW(4)
  ) dut_t (
    .clock(clock), .aclr(aclr), .clken(clken), .in_valid(in_valid), .in_ready(in_ready_t),
    .dataa(dataa), .datab(datab), .is_signed(is_signed), .in_tag(in_tag),
    .out_valid(out_valid_t), .out_ready(out_ready), .result(result_t), .out_tag(out_tag_t),
    .busy(busy_t)
`ifdef LOCAL_MULT_OVF_EN
    , .ovf(ovf_t)
`endif
  );

  typedef struct {
    logic [127:0] p128;
    logic [63:0]  p64;
    logic         ovf64;
    logic [3:0]   tag;
  } exp_t;

  exp_t q[$];
  int   n_vec   = 0;
  int   n_err   = 0;
  int   drained = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Exact product as a 130-bit signed number, then range tests for the 64-bit result.
  function automatic exp_t model(input logic [63:0] a, input logic [63:0] b,
                                 input logic s, input logic [3:0] t);
    exp_t e;
    logic signed [129:0] ea, eb, p;
    ea = {{66{s & a[63]}}, a};
    eb = {{66{s & b[63]}}, b};
    p  = ea * eb;
    e.p128 = p[127:0];
    e.p64  = p[63:0];
    if (s) e.ovf64 = (p < -(130'sd1 <<< 63)) || (p >= (130'sd1 <<< 63));
    else   e.ovf64 = (p >= (130'sd1 <<< 64));
    e.tag  = t;
    return e;
  endfunction

  function automatic logic [63:0] rand64();
    if ($urandom_range(0, 3) == 0) return 64'($urandom_range(0, 15));
    return {$urandom, $urandom};
  endfunction

  // Drive one cycle at the falling edge, check outputs against the scoreboard,
  // then advance the scoreboard by what the coming rising edge will do.
  task automatic cycle(input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic s, input logic [3:0] t, input logic ordy,
                       input logic ce, input logic rst, output logic acc);
    int occ;
    @(negedge clock);
    aclr = rst; clken = ce; in_valid = v; dataa = a; datab = b;
    is_signed = s; in_tag = t; out_ready = ordy;
    #1;
    occ = q.size();
    if (!rst) begin
      check("in_ready", 128'(in_ready), 128'(ce && (occ < STAGES || ordy)));
      check("in_ready_t", 128'(in_ready_t), 128'(ce && (occ < STAGES || ordy)));
    end
    check("busy", 128'(busy), 128'(occ != 0));
    if (occ == 0) begin
      check("idle_out_valid", 128'(out_valid), 128'(0));
      check("idle_out_valid_t", 128'(out_valid_t), 128'(0));
    end else begin
      if (out_valid) begin
        check("result", result, q[0].p128);
        check("out_tag", 128'(out_tag), 128'(q[0].tag));
`ifdef LOCAL_MULT_OVF_EN
        check("ovf_full", 128'(ovf), 128'(0));
`endif
      end
      if (out_valid_t) begin
        check("result_t", 128'(result_t), 128'(q[0].p64));
        check("out_tag_t", 128'(out_tag_t), 128'(q[0].tag));
`ifdef LOCAL_MULT_OVF_EN
        check("ovf_t", 128'(ovf_t), 128'(q[0].ovf64));
`endif
      end
    end
    acc = 1'b0;
    if (rst) begin
      q.delete();
    end else if (ce) begin
      acc = v && (occ < STAGES || ordy);
      if (ordy && out_valid && occ != 0) begin
        void'(q.pop_front());
        drained++;
      end
      if (acc) q.push_back(model(a, b, s, t));
    end
  endtask

  task automatic idle(input logic ordy, input logic ce);
    logic acc;
    cycle(1'b0, 64'd0, 64'd0, 1'b0, 4'd0, ordy, ce, 1'b0, acc);
  endtask

  task automatic run_until_out(output int lat);
    lat = 99;
    for (int i = 1; i <= 10; i++) begin
      idle(1'b1, 1'b1);
      if (out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  initial begin
    logic acc;
    int   lat;
    int   idx;
    int   d0;

    aclr = 1'b1; clken = 1'b1; in_valid = 1'b0; is_signed = 1'b0; out_ready = 1'b1;
    dataa = '0; datab = '0; in_tag = '0;
    repeat (2) @(posedge clock);

    // Reset state
    @(negedge clock);
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_result", result, 128'(0));
    check("rst_out_tag", 128'(out_tag), 128'(0));
`ifdef LOCAL_MULT_OVF_EN
    check("rst_ovf_t", 128'(ovf_t), 128'(0));
`endif

    // 1: unsigned 3*5, latency
    cycle(1'b1, 64'd3, 64'd5, 1'b0, 4'd2, 1'b1, 1'b1, 1'b0, acc);
    run_until_out(lat);
    check("t1_latency", 128'(lat), 128'(STAGES));
    check("t1_result", result, 128'd15);
    check("t1_out_tag", 128'(out_tag), 128'd2);

    // 2: signed vs unsigned interpretation of the same bits
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 1'b1, 4'd3, 1'b1, 1'b1, 1'b0, acc);
    run_until_out(lat);
    check("t2_signed", result, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF9);
    cycle(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd7, 1'b0, 4'd4, 1'b1, 1'b1, 1'b0, acc);
    run_until_out(lat);
    check("t2_unsigned", result, 128'h6_FFFF_FFFF_FFFF_FFF9);
    idle(1'b1, 1'b1);

    // 3: stream 8 ops with a stall on cycles 3..8
    idx = 0;
    d0  = drained;
    for (int c = 0; c < 40 && (idx < 8 || q.size() != 0); c++) begin
      cycle(idx < 8, rand64(), rand64(), 1'($urandom_range(0, 1)), 4'(idx),
            !(c >= 3 && c <= 8), 1'b1, 1'b0, acc);
      if (acc) idx++;
      if (c == 8) begin
        check("t3_in_ready_full", 128'(in_ready), 128'(0));
        check("t3_out_valid_held", 128'(out_valid), 128'(1));
        check("t3_ops_held", 128'(idx), 128'(STAGES));
      end
    end
    check("t3_drained", 128'(drained - d0), 128'd8);

    // 4: clken low for 4 cycles mid-stream
    for (int c = 0; c < 3; c++)
      cycle(1'b1, rand64(), rand64(), 1'b0, 4'(c + 8), 1'b1, 1'b1, 1'b0, acc);
    for (int c = 0; c < 4; c++) begin
      cycle(1'b1, rand64(), rand64(), 1'b1, 4'hE, 1'b1, 1'b0, 1'b0, acc);
      check("t4_in_ready", 128'(in_ready), 128'(0));
      check("t4_busy", 128'(busy), 128'(1));
    end
    for (int c = 0; c < 8; c++) idle(1'b1, 1'b1);

    // 5: reset with 3 ops in flight
    for (int c = 0; c < 3; c++)
      cycle(1'b1, rand64(), rand64(), 1'b0, 4'(c + 1), 1'b1, 1'b1, 1'b0, acc);
    cycle(1'b0, 64'd0, 64'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b1, acc);
    idle(1'b1, 1'b1);
    check("t5_out_valid", 128'(out_valid), 128'(0));
    check("t5_busy", 128'(busy), 128'(0));
    check("t5_result", result, 128'(0));
    check("t5_out_tag", 128'(out_tag), 128'(0));
    for (int c = 0; c < 6; c++) idle(1'b1, 1'b1);

    // 6: truncation to 64 bits
    cycle(1'b1, 64'h1_0000_0000, 64'h1_0000_0000, 1'b0, 4'd6, 1'b1, 1'b1, 1'b0, acc);
    run_until_out(lat);
    check("t6_trunc_result", 128'(result_t), 128'(0));
    check("t6_full_result", result, 128'h1_0000_0000_0000_0000);
`ifdef LOCAL_MULT_OVF_EN
    check("t6_ovf_unsigned", 128'(ovf_t), 128'(1));
`endif
    cycle(1'b1, 64'hFFFF_FFFF_8000_0000, 64'h8000_0000, 1'b1, 4'd7, 1'b1, 1'b1, 1'b0, acc);
    run_until_out(lat);
    check("t6_signed_result", 128'(result_t), 128'(64'hC000_0000_0000_0000));
`ifdef LOCAL_MULT_OVF_EN
    check("t6_ovf_signed", 128'(ovf_t), 128'(0));
`endif

    // Randomised traffic with random stalls and clock-enable gaps
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 9) < 7), rand64(), rand64(), 1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)), 1'($urandom_range(0, 9) < 6),
            1'($urandom_range(0, 9) != 0), 1'b0, acc);
    end
    for (int i = 0; i < 20 && q.size() != 0; i++) idle(1'b1, 1'b1);
    check("drain_empty", 128'(q.size()), 128'(0));
    idle(1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
